// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result bus between the control unit and the
// multi-cycle ALU.
//   master : drives A_bus, B_bus, Control, enable; observes busy, done,
//            C_bus, Z_flag, dz_flag.
//   slave  : the ALU side (inverse directions).
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] A_bus;
    logic [WIDTH-1:0] B_bus;
    logic [3:0]       Control;
    logic             enable;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] C_bus;
    logic             Z_flag;
    logic             dz_flag;

    modport master (
        output A_bus, B_bus, Control, enable,
        input  busy, done, C_bus, Z_flag, dz_flag
    );

    modport slave (
        input  A_bus, B_bus, Control, enable,
        output busy, done, C_bus, Z_flag, dz_flag
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle, width-parametrised ALU for the convolution datapath.
// Single-cycle ops (ADD/SUB/PASS/INC/DEC/RESET) finish one cycle after
// enable; MUL (radix-2 shift-add) and MOD/DIV (restoring) take WIDTH+1.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : alu_seq_if.slave -- operands A_bus/B_bus, opcode Control,
//            start request enable; status busy/done; result C_bus with
//            Z_flag (C_bus == 0) and dz_flag (last MOD/DIV had B == 0).
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FINISH
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP   = 4'b0000,
        OP_ADD   = 4'b0001,
        OP_SUB   = 4'b0010,
        OP_MUL   = 4'b0011,
        OP_MOD   = 4'b0100,
        OP_PASSA = 4'b0101,
        OP_PASSB = 4'b0110,
        OP_INC   = 4'b0111,
        OP_DEC   = 4'b1000,
        OP_RST   = 4'b1001,
        OP_DIV   = 4'b1010
    } op_e;

    state_e           state_q;
    op_e              op_q;
    // a_q: multiplicand (MUL) or dividend shifting into quotient (MOD/DIV)
    // b_q: multiplier (MUL) or divisor (MOD/DIV)
    // acc_q: product accumulator (MUL), remainder (MOD/DIV), or the
    //        precomputed single-cycle result
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] c_q;
    logic             z_q;
    logic             dz_q;

    op_e              op_in_d;
    logic [WIDTH-1:0] single_d;
    logic             multi_d;
    logic [WIDTH:0]   rem_sh_d;
    logic             rem_ge_d;
    logic [WIDTH-1:0] rem_nx_d;
    logic [WIDTH-1:0] result_d;
    logic             dz_d;

    // Decode of the incoming request; single-cycle results are computed
    // straight from the bus so FINISH only has to copy acc_q.
    always_comb begin
        op_in_d  = op_e'(bus.Control);
        single_d = '0;
        multi_d  = 1'b0;
        unique case (op_in_d)
            OP_ADD:   single_d = bus.A_bus + bus.B_bus;
            OP_SUB:   single_d = bus.A_bus - bus.B_bus;
            OP_PASSA: single_d = bus.A_bus;
            OP_PASSB: single_d = bus.B_bus;
            OP_INC:   single_d = bus.A_bus + WIDTH'(1);
            OP_DEC:   single_d = bus.A_bus - WIDTH'(1);
            OP_MUL:   multi_d  = 1'b1;
            OP_MOD,
            OP_DIV:   multi_d  = (bus.B_bus != '0);
            default:  single_d = '0;
        endcase
    end

    // One restoring-division step; the remainder needs one extra bit
    // after the shift before the compare.
    always_comb begin
        rem_sh_d = {acc_q, a_q[WIDTH-1]};
        rem_ge_d = (rem_sh_d >= {1'b0, b_q});
        rem_nx_d = rem_ge_d ? WIDTH'(rem_sh_d - {1'b0, b_q})
                            : rem_sh_d[WIDTH-1:0];
    end

    // b_q still holds the divisor at FINISH, so a zero divisor is
    // detected there; acc_q was loaded with 0 in that case.
    always_comb begin
        dz_d     = ((op_q == OP_MOD) || (op_q == OP_DIV)) && (b_q == '0);
        result_d = ((op_q == OP_DIV) && !dz_d) ? a_q : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= '0;
            z_q     <= 1'b1;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.enable) begin
                        op_q   <= op_in_d;
                        a_q    <= bus.A_bus;
                        b_q    <= bus.B_bus;
                        acc_q  <= single_d;
                        busy_q <= 1'b1;
                        if (multi_d) begin
                            cnt_q   <= CNT_W'(WIDTH);
                            state_q <= S_ITER;
                        end else begin
                            state_q <= S_FINISH;
                        end
                    end
                end
                S_ITER: begin
                    if (op_q == OP_MUL) begin
                        if (b_q[0]) begin
                            acc_q <= acc_q + a_q;
                        end
                        a_q <= a_q << 1;
                        b_q <= b_q >> 1;
                    end else begin
                        acc_q <= rem_nx_d;
                        a_q   <= {a_q[WIDTH-2:0], rem_ge_d};
                    end
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    c_q     <= result_d;
                    z_q     <= (result_d == '0);
                    dz_q    <= dz_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.C_bus   = c_q;
    assign bus.Z_flag  = z_q;
    assign bus.dz_flag = dz_q;

endmodule
